// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam logic [31:0] NOP_WORD   = 32'h0;
    localparam int unsigned ADDR_SHIFT = 2;

endpackage

// File: rtl/loader_addr_ctr.sv
// Word write pointer with synchronous clear, increment and terminal-count flag.
module loader_addr_ctr #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic         tc_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

    // Pointer sits on the last memory word.
    assign tc_c = &ptr;

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program into instruction memory, zero-fills the tail and holds the
// CPU in reset until the image is complete.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic                  in_last_i,
    output logic                  in_ready_o,
    output logic                  im_we_o,
    output logic [31:0]           im_addr_o,
    output logic [DATA_W-1:0]     im_data_o,
    output logic                  cpu_rst_n_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DEPTH_LOG2:0]   word_cnt_o
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << DEPTH_LOG2;

    state_t                state;
    logic [DEPTH_LOG2-1:0] ptr;
    logic                  ptr_tc;
    logic                  accept;
    logic                  ptr_clr;
    logic                  ptr_inc;

    // A restart always wins over a beat presented in the same cycle.
    assign accept  = (state == ST_LOAD) && in_valid_i && in_ready_o && !start_i;
    assign ptr_clr = start_i;
    assign ptr_inc = !start_i && (accept || (state == ST_FILL));

    loader_addr_ctr #(
        .W (DEPTH_LOG2)
    ) u_addr_ctr (
        .clk  (clk_i),
        .rst  (rst_i),
        .clr  (ptr_clr),
        .inc  (ptr_inc),
        .ptr  (ptr),
        .tc_c (ptr_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            in_ready_o  <= 1'b0;
            im_we_o     <= 1'b0;
            im_addr_o   <= '0;
            im_data_o   <= '0;
            cpu_rst_n_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            word_cnt_o  <= '0;
        end else begin
            im_we_o <= 1'b0;
            if (start_i) begin
                // Ready stays low one cycle so a discarded beat is re-sent.
                state       <= ST_LOAD;
                in_ready_o  <= 1'b0;
                cpu_rst_n_o <= 1'b0;
                done_o      <= 1'b0;
                err_o       <= 1'b0;
                word_cnt_o  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        in_ready_o <= 1'b0;
                    end
                    ST_LOAD: begin
                        in_ready_o <= 1'b1;
                        if (accept) begin
                            im_we_o   <= 1'b1;
                            im_addr_o <= 32'(ptr) << ADDR_SHIFT;
                            im_data_o <= in_data_i;
                            if (word_cnt_o != CNT_MAX) begin
                                word_cnt_o <= word_cnt_o + CNT_W'(1);
                            end
                            if (in_last_i) begin
                                state      <= ptr_tc ? ST_RUN : ST_FILL;
                                in_ready_o <= 1'b0;
                            end else if (ptr_tc) begin
                                state      <= ST_ERR;
                                in_ready_o <= 1'b0;
                            end
                        end
                    end
                    ST_FILL: begin
                        in_ready_o <= 1'b0;
                        im_we_o    <= 1'b1;
                        im_addr_o  <= 32'(ptr) << ADDR_SHIFT;
                        im_data_o  <= DATA_W'(NOP_WORD);
                        if (ptr_tc) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Entered on the last write; release the CPU one cycle later.
                        in_ready_o  <= 1'b0;
                        cpu_rst_n_o <= 1'b1;
                        done_o      <= 1'b1;
                    end
                    ST_ERR: begin
                        in_ready_o  <= 1'b0;
                        cpu_rst_n_o <= 1'b0;
                        err_o       <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed plus randomized bench for instr_mem_loader against an image-level model.
module tb_instr_mem_loader;

    localparam int unsigned DEPTH_LOG2 = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    logic              clk;
    logic              rst_i;
    logic              start_i;
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_last_i;
    logic              in_ready_o;
    logic              im_we_o;
    logic [31:0]       im_addr_o;
    logic [DATA_W-1:0] im_data_o;
    logic              cpu_rst_n_o;
    logic              done_o;
    logic              err_o;
    logic [DEPTH_LOG2:0] word_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] prog_q[$];

    instr_mem_loader #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .im_we_o     (im_we_o),
        .im_addr_o   (im_addr_o),
        .im_data_o   (im_data_o),
        .cpu_rst_n_o (cpu_rst_n_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .word_cnt_o  (word_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every memory write as seen mid-cycle.
    always @(negedge clk) begin
        if (im_we_o === 1'b1) begin
            wr_addr_q.push_back(im_addr_o);
            wr_data_q.push_back(im_data_o);
            last_we_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
        check({tag, "_im_we"}, 32'(im_we_o), 32'd0);
        check({tag, "_im_addr"}, im_addr_o, 32'd0);
        check({tag, "_im_data"}, im_data_o, 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt_o), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge following the sampling edge.
    task automatic pulse_start();
        start_i = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Present one word after 'idle' bubble cycles; ok when the handshake completes.
    task automatic push_word(input logic [31:0] d, input bit last, input int idle,
                             input int limit, output bit ok);
        bit rdy;
        ok = 1'b0;
        in_valid_i = 1'b0;
        repeat (idle) @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        for (int t = 0; t < limit && !ok; t++) begin
            rdy = in_ready_o;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic send_prog(input int last_at, input int max_idle, input string tag);
        bit ok;
        for (int i = 0; i < prog_q.size(); i++) begin
            push_word(prog_q[i], (i == last_at), $urandom_range(max_idle, 0), 50, ok);
            check($sformatf("%s_accept%0d", tag, i), 32'(ok), 32'd1);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 300 && cpu_rst_n_o !== 1'b1; t++) @(negedge clk);
        check({tag, "_cpu_released"}, 32'(cpu_rst_n_o), 32'd1);
        check({tag, "_release_timing"}, 32'(cyc), 32'(last_we_cyc + 1));
    endtask

    // Expected image: program words from address 0, zeros above, every word written once.
    task automatic verify_image(input string tag);
        int n;
        logic [31:0] exp_d;
        n = prog_q.size();
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(DEPTH));
        for (int i = 0; i < wr_addr_q.size() && i < int'(DEPTH); i++) begin
            exp_d = (i < n) ? prog_q[i] : 32'h0;
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], 32'(i * 4));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_d);
        end
        check({tag, "_word_cnt"}, 32'(word_cnt_o), 32'(n));
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    endtask

    initial begin
        bit ok;
        bit found;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        in_last_i  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(in_ready_o), 32'd0);

        // Three-word program, zero fill of the tail.
        prog_q = '{32'h20010005, 32'h20020003, 32'h00221820};
        pulse_start();
        send_prog(2, 0, "short");
        wait_done("short");
        verify_image("short");

        // Full 32-word program, no fill, random bubbles.
        prog_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) prog_q.push_back($urandom);
        pulse_start();
        send_prog(int'(DEPTH) - 1, 2, "full");
        wait_done("full");
        verify_image("full");

        // Overflow: 33 words, no last marker.
        prog_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) prog_q.push_back($urandom);
        pulse_start();
        send_prog(-1, 0, "ovf");
        push_word(32'hDEADBEEF, 1'b0, 0, 10, ok);
        check("ovf_word33_refused", 32'(ok), 32'd0);
        check("ovf_nwrites", 32'(wr_addr_q.size()), 32'(DEPTH));
        for (int i = 0; i < wr_addr_q.size() && i < int'(DEPTH); i++) begin
            check($sformatf("ovf_addr%0d", i), wr_addr_q[i], 32'(i * 4));
            check($sformatf("ovf_data%0d", i), wr_data_q[i], prog_q[i]);
        end
        check("ovf_err", 32'(err_o), 32'd1);
        check("ovf_cpu_held", 32'(cpu_rst_n_o), 32'd0);
        check("ovf_done", 32'(done_o), 32'd0);
        check("ovf_ready", 32'(in_ready_o), 32'd0);
        check("ovf_word_cnt", 32'(word_cnt_o), 32'(DEPTH));
        pulse_start();
        check("ovf_err_cleared", 32'(err_o), 32'd0);

        // Valid toggling 1,0,1,0 over four words.
        prog_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            push_word(prog_q[i], (i == 3), 1, 50, ok);
            check($sformatf("toggle_accept%0d", i), 32'(ok), 32'd1);
        end
        wait_done("toggle");
        verify_image("toggle");

        // Restart from RUN drops the CPU reset on the next edge, then a one-word reload.
        pulse_start();
        check("rerun_cpu_held", 32'(cpu_rst_n_o), 32'd0);
        check("rerun_done_low", 32'(done_o), 32'd0);
        prog_q = '{32'hCAFEF00D};
        send_prog(0, 0, "one");
        wait_done("one");
        verify_image("one");

        // Randomized program lengths and bubble patterns.
        for (int r = 0; r < 3; r++) begin
            int len;
            len = $urandom_range(DEPTH - 1, 1);
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back($urandom);
            pulse_start();
            send_prog(len - 1, 3, $sformatf("rnd%0d", r));
            wait_done($sformatf("rnd%0d", r));
            verify_image($sformatf("rnd%0d", r));
        end

        // Start and a valid beat in the same cycle: the beat is discarded.
        pulse_start();
        for (int t = 0; t < 20 && in_ready_o !== 1'b1; t++) @(negedge clk);
        check("race_ready_seen", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        in_data_i  = 32'h55AA55AA;
        start_i    = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        check("race_no_write", 32'(im_we_o), 32'd0);
        check("race_ready_low", 32'(in_ready_o), 32'd0);
        check("race_word_cnt", 32'(word_cnt_o), 32'd0);

        // Reset asserted during fill at address 0x40.
        prog_q = '{32'h0BADC0DE};
        pulse_start();
        send_prog(0, 0, "rstfill");
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            if (im_we_o === 1'b1 && im_addr_o === 32'h40) found = 1'b1;
            else @(negedge clk);
        end
        check("rstfill_reached_0x40", 32'(found), 32'd1);
        rst_i = 1'b1;
        #1;
        check_all_zero("rstfill_async");
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        repeat (5) @(negedge clk);
        check("rstfill_no_writes", 32'(wr_addr_q.size()), 32'd0);
        check("rstfill_idle_ready", 32'(in_ready_o), 32'd0);
        check("rstfill_cpu_held", 32'(cpu_rst_n_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
